// File: rtl/arb4_rr.sv
// rtl/arb4_rr.sv - four-requester round-robin arbiter with registered one-hot grant
// Optional grant timeout, MASK and TO pulse enabled by defining ARB4_TIMEOUT_EN.
module arb4_rr #(
    parameter int TIMEOUT = 16
) (
    input  logic       C,
    input  logic       CLRN,
    input  logic       CE,
    input  logic [3:0] R,
    output logic [3:0] G,
    output logic       GV,
    output logic [1:0] GID,
    output logic       TO
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] g_q, g_d;
    logic [1:0] gid_q, gid_d;
    logic [1:0] ptr_q, ptr_d;

    logic [3:0] elig;
    logic [3:0] arb_req;
    logic [1:0] arb_ptr;
    logic       found;
    logic [1:0] win;
    logic       owner_req;
    logic       timeout_hit;
    logic       revoke;
    logic       new_grant;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("arb4_rr: TIMEOUT must be in 2..255");
    end

    assign owner_req = R[gid_q];
    assign revoke    = (state_q == GRANT) && (!owner_req || timeout_hit);
    // After a release or timeout the search restarts just past the old owner.
    assign arb_ptr   = (state_q == GRANT) ? gid_q + 2'd1 : ptr_q;
    // A timed-out owner still has R high; keep it out of this edge's search.
    assign arb_req   = timeout_hit ? (elig & ~g_q) : elig;
    assign new_grant = found && ((state_q == IDLE) || revoke);

    always_comb begin
        found = 1'b0;
        win   = arb_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (arb_req[arb_ptr + 2'(i)]) begin
                found = 1'b1;
                win   = arb_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    g_d     = 4'b0001 << win;
                    gid_d   = win;
                end
            end
            GRANT: begin
                if (revoke) begin
                    ptr_d = gid_q + 2'd1;
                    if (found) begin
                        g_d   = 4'b0001 << win;
                        gid_d = win;
                    end else begin
                        state_d = IDLE;
                        g_d     = 4'b0000;
                        gid_d   = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            g_q     <= 4'b0000;
            gid_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else if (CE) begin
            state_q <= state_d;
            g_q     <= g_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB4_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic       to_q, to_d;

    assign elig        = R & ~mask_q;
    assign timeout_hit = (state_q == GRANT) && owner_req && (cnt_q == CNT_LAST);

    always_comb begin
        mask_d = mask_q & R;
        to_d   = 1'b0;
        cnt_d  = cnt_q;
        if (timeout_hit) begin
            mask_d[gid_q] = 1'b1;
            to_d          = 1'b1;
        end
        if (new_grant) begin
            cnt_d = 8'd0;
        end else if (state_q == GRANT && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            cnt_q  <= 8'd0;
            mask_q <= 4'b0000;
            to_q   <= 1'b0;
        end else if (CE) begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            to_q   <= to_d;
        end
    end

    assign TO = to_q;
`else
    assign elig        = R;
    assign timeout_hit = 1'b0;
    assign TO          = 1'b0;
`endif

    assign G   = g_q;
    assign GV  = |g_q;
    assign GID = gid_q;

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter that shares one 4-input gate/LUT resource in the Unisims primitive library. Requesters raise a request bit and hold it while they own the resource. The arbiter issues a registered one-hot grant and hands the resource over on release. An optional timeout revokes a grant that has been held too long.

## Interface
- TIMEOUT, 16: cycles a grant may be held before forced revocation (2..255); used only with ARB4_TIMEOUT_EN.
- C  input  1  clock, rising-edge active.
- CLRN  input  1  asynchronous reset, active-low.
- CE  input  1  clock enable; when low, all state is frozen.
- R  input  4  request bits; R[i] is held high for the whole ownership of requester i.
- G  output  4  one-hot grant, registered.
- GV  output  1  grant valid; equals |G.
- GID  output  2  index of the granted requester; 0 when GV=0.
- TO  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- One clock and reset: C, with CLRN asynchronous and active-low. Reset values: G=0, GV=0, GID=0, TO=0, PTR=0, state IDLE, CNT=0, MASK=0.
- PTR[1:0] is the highest-priority index. Search order is PTR, PTR+1, PTR+2, PTR+3, modulo 4.
- Eligible requests: E = R & ~MASK. Without the macro, MASK is always 0.
- State IDLE:
  - If E≠0, grant the first set bit in search order and go to GRANT; CNT=0.
  - Otherwise stay in IDLE.
- State GRANT, owner k:
  - R[k]=1 and no timeout: hold G; CNT increments.
  - R[k]=0 (release): PTR=k+1 mod 4. Re-arbitrate on the same edge from the new PTR over E.
    - If any bit is eligible, grant it directly (zero dead cycles) and clear CNT.
    - Otherwise G=0 and go to IDLE.
- Timeout (macro only): in GRANT, when CNT=TIMEOUT-1 and R[k] is still 1:
  - G=0; MASK[k]=1; TO=1 for one cycle; PTR=k+1.
  - Re-arbitrate on the same edge, exactly as on a release.
- MASK[i] clears on any edge where R[i]=0. A masked requester must drop R for at least one cycle before it can be granted again.
- Reset mid-grant: G drops immediately (asynchronously) and PTR returns to 0.
- CE=0: no state change, outputs held, CNT does not advance. A release seen while CE=0 is acted on at the first edge with CE=1, if R is still low then.
- CNT width is 8 bits and saturates, never wraps. It is not implemented without the macro.

## Timing
- Grant latency: R rising before edge n gives G at edge n (visible in the cycle after edge n). This holds when IDLE, or when the owner is releasing on edge n.
- Release latency: R[k] low before edge n clears G[k] at edge n. A handover to the next requester happens at that same edge.
- G, GV, GID and TO all change only on rising C edges, except for asynchronous reset.
- Timeout fires at the TIMEOUT-th edge after the grant edge. G[k] is therefore high for exactly TIMEOUT cycles.
- Simultaneous release and timeout on the same edge: treated as a release. TO=0 and MASK is not set.

## Configuration
- ARB4_TIMEOUT_EN defined:
  - CNT, MASK and timeout revocation are present.
  - TO pulses as specified.
- ARB4_TIMEOUT_EN undefined:
  - No CNT and no MASK logic.
  - A grant is held until release, indefinitely.
  - TO is tied 0 and TIMEOUT is ignored.

## Test plan
- Reset then single request: R=4'b0100 from cycle 2 → at edge 2, G=4'b0100, GV=1, GID=2. Drop R at cycle 6 → G=0 at edge 6; PTR=3.
- Fairness: R=4'b1111 held constant, each owner releasing for one cycle after 2 cycles of ownership → grant order 0,1,2,3,0 with no dead cycle between grants.
- Priority after wrap: PTR=3 (owner 2 released), R=4'b1001 → G=4'b1000. After its release → G=4'b0001.
- CE freeze: grant to 1, then CE=0 for 5 cycles with R[1] dropped → G stays 4'b0010. After CE returns high, G clears on the next edge.
- Async reset mid-grant: G=4'b0100, CLRN pulled low between edges → G=0 and GV=0 immediately. After CLRN rises with R=4'b1111 → G=4'b0001.
- Timeout (macro, TIMEOUT=4): R=4'b0011 held, owner 0 → G=4'b0001 for 4 cycles, then TO=1 and G=4'b0010. Requester 0 is not re-granted until R[0] has been low for at least one edge.
